// File: rtl/dmg_irq_ctrl.sv
// Interrupt flag (IF) controller for the SM83 core: request edge capture, ack clear, IF MMIO access.
// Define IRQ_SYNC_EN to add a two-flop synchronizer on every IRQ_REQ line (for asynchronous sources).
module dmg_irq_ctrl #(
    parameter int          NUM_IRQ = 5,
    parameter logic [15:0] IF_ADDR = 16'hFF0F
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_IRQ-1:0] IRQ_REQ,
    input  logic [15:0]        A,
    input  logic [7:0]         D_IN,
    output logic [7:0]         D_OUT,
    output logic               D_OE,
    input  logic               RD,
    input  logic               WR,
    input  logic               MMIO_REQ,
    output logic [7:0]         CPU_IRQ_TRIG,
    input  logic [7:0]         CPU_IRQ_ACK
);

    logic [NUM_IRQ-1:0] req_p0;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync_p0;
    logic [NUM_IRQ-1:0] sync_p1;

    // Synchronizer resets to ones so a line already high at release looks like "no edge"
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
        end else begin
            sync_p0 <= IRQ_REQ;
            sync_p1 <= sync_p0;
        end
    end

    assign req_p0 = sync_p1;
`else
    assign req_p0 = IRQ_REQ;
`endif

    logic [NUM_IRQ-1:0] prev_p1;
    logic [NUM_IRQ-1:0] if_p1;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] ack;
    logic [NUM_IRQ-1:0] if_nxt;
    logic               hit;
    logic               wr_hit;
    logic [7:0]         trig;
    logic [7:0]         dout;
    logic               unused_ok;

    assign hit    = MMIO_REQ && (A == IF_ADDR);
    assign wr_hit = WR && hit;
    assign rise   = req_p0 & ~prev_p1;
    assign ack    = CPU_IRQ_ACK[NUM_IRQ-1:0];

    // Upper D_IN / ACK bits have no flag behind them
    assign unused_ok = ^{D_IN, CPU_IRQ_ACK};

    // Per-bit priority, lowest first: ack clear, then MMIO write, then a new edge always wins
    function automatic logic [NUM_IRQ-1:0] next_flags(
        input logic [NUM_IRQ-1:0] cur,
        input logic [NUM_IRQ-1:0] rise_i,
        input logic [NUM_IRQ-1:0] ack_i,
        input logic [NUM_IRQ-1:0] wdata,
        input logic               wr_i
    );
        logic [NUM_IRQ-1:0] f;
        f = cur & ~ack_i;
        if (wr_i) begin
            f = wdata;
        end
        return f | rise_i;
    endfunction

    assign if_nxt = next_flags(if_p1, rise, ack, D_IN[NUM_IRQ-1:0], wr_hit);

    // Edge-detect / flag stage
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prev_p1 <= '1;
            if_p1   <= '0;
        end else begin
            prev_p1 <= req_p0;
            if_p1   <= if_nxt;
        end
    end

    always_comb begin
        trig                = '0;
        trig[NUM_IRQ-1:0]   = if_p1;
        dout                = '1;
        dout[NUM_IRQ-1:0]   = if_p1;
    end

    assign CPU_IRQ_TRIG = trig;
    assign D_OUT        = dout;
    assign D_OE         = RD && hit;

endmodule

// File: tb/tb_dmg_irq_ctrl.sv
// Scoreboard bench for dmg_irq_ctrl: directed scenarios plus randomized traffic against a flag-level model.
module tb_dmg_irq_ctrl;

`ifdef IRQ_SYNC_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif

    logic        CLK;
    logic        RESET;
    logic [4:0]  IRQ_REQ;
    logic [15:0] A;
    logic [7:0]  D_IN;
    logic [7:0]  D_OUT;
    logic        D_OE;
    logic        RD;
    logic        WR;
    logic        MMIO_REQ;
    logic [7:0]  CPU_IRQ_TRIG;
    logic [7:0]  CPU_IRQ_ACK;

    dmg_irq_ctrl #(.NUM_IRQ(5), .IF_ADDR(16'hFF0F)) dut (
        .CLK(CLK), .RESET(RESET), .IRQ_REQ(IRQ_REQ), .A(A), .D_IN(D_IN),
        .D_OUT(D_OUT), .D_OE(D_OE), .RD(RD), .WR(WR), .MMIO_REQ(MMIO_REQ),
        .CPU_IRQ_TRIG(CPU_IRQ_TRIG), .CPU_IRQ_ACK(CPU_IRQ_ACK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] pre_dout;
        logic       pre_oe;
        logic [7:0] trig;
        logic [7:0] dout;
        logic       oe;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_cyc   = 0;

    // Reference model: the five pending flags, last seen request level, and the synchronizer delay line
    logic [4:0]  m_if;
    logic [4:0]  m_prev;
    logic [4:0]  hist[$];

    task automatic model_reset();
        m_if   = 5'h00;
        m_prev = 5'h1F;
        hist.delete();
        repeat (DLY) hist.push_back(5'h1F);
    endtask

    task automatic cycle(input logic rst, input logic [4:0] req, input logic [7:0] ack,
                         input logic [15:0] a, input logic mreq, input logic [7:0] din,
                         input logic rd, input logic wr);
        exp_t       e;
        logic       hit;
        logic [4:0] seen;
        @(negedge CLK);
        RESET = rst; IRQ_REQ = req; CPU_IRQ_ACK = ack; A = a;
        MMIO_REQ = mreq; D_IN = din; RD = rd; WR = wr;
        hit = mreq && (a == 16'hFF0F);
        if (rst) model_reset();
        e.pre_dout = {3'b111, m_if};
        e.pre_oe   = rd && hit;
        if (!rst) begin
            if (DLY == 0) seen = req;
            else begin
                seen = hist.pop_front();
                hist.push_back(req);
            end
            for (int i = 0; i < 5; i++) begin
                if (seen[i] && !m_prev[i])  m_if[i] = 1'b1;
                else if (wr && hit)         m_if[i] = din[i];
                else if (ack[i])            m_if[i] = 1'b0;
            end
            m_prev = seen;
        end
        e.trig = {3'b000, m_if};
        e.dout = {3'b111, m_if};
        e.oe   = rd && hit;
        #1 sb.push_back(e);
    endtask

    task automatic io(input logic [4:0] req, input logic [7:0] ack);
        cycle(1'b0, req, ack, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic mm(input logic rd, input logic wr, input logic [7:0] din,
                      input logic [4:0] req, input logic [7:0] ack);
        cycle(1'b0, req, ack, 16'hFF0F, 1'b1, din, rd, wr);
    endtask

    task automatic chk(input logic [7:0] et, input logic eo, input logic [7:0] ed, input string nm);
        @(posedge CLK);
        #1;
        n_tests++;
        if (CPU_IRQ_TRIG !== et) begin
            n_fail++;
            $display("FAIL %s: CPU_IRQ_TRIG=%h expected %h", nm, CPU_IRQ_TRIG, et);
        end
        n_tests++;
        if (D_OE !== eo) begin
            n_fail++;
            $display("FAIL %s: D_OE=%b expected %b", nm, D_OE, eo);
        end
        n_tests++;
        if (D_OUT !== ed) begin
            n_fail++;
            $display("FAIL %s: D_OUT=%h expected %h", nm, D_OUT, ed);
        end
    endtask

    task automatic async_reset();
        #2;
        RESET = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (CPU_IRQ_TRIG !== 8'h00 || D_OUT !== 8'hE0) begin
            n_fail++;
            $display("FAIL async_rst: TRIG=%h D_OUT=%h expected 00/e0", CPU_IRQ_TRIG, D_OUT);
        end
    endtask

    // Monitor: samples combinational read data before the edge and flops after it, then scores
    initial begin
        logic [7:0] p_dout;
        logic       p_oe;
        exp_t       e;
        forever begin
            @(negedge CLK);
            #2;
            p_dout = D_OUT;
            p_oe   = D_OE;
            @(posedge CLK);
            #1;
            n_cyc++;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty: cycle %0d has no expectation queued", n_cyc);
            end else begin
                e = sb.pop_front();
                if (CPU_IRQ_TRIG !== e.trig || D_OUT !== e.dout || D_OE !== e.oe ||
                    p_dout !== e.pre_dout || p_oe !== e.pre_oe) begin
                    n_fail++;
                    $display("FAIL sb cycle %0d: trig=%h/%h dout=%h/%h oe=%b/%b pre_dout=%h/%h pre_oe=%b/%b (got/expected)",
                             n_cyc, CPU_IRQ_TRIG, e.trig, D_OUT, e.dout, D_OE, e.oe,
                             p_dout, e.pre_dout, p_oe, e.pre_oe);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  r_req;
        logic [7:0]  r_ack;
        logic [15:0] r_a;
        RESET = 1'b1; IRQ_REQ = 5'b00100; A = 16'h0000; D_IN = 8'h00;
        RD = 1'b0; WR = 1'b0; MMIO_REQ = 1'b0; CPU_IRQ_ACK = 8'h00;
        model_reset();

        // Line held high across reset release must not fire; re-arm after one low sample
        repeat (2) cycle(1'b1, 5'b00100, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3 + DLY) io(5'b00100, 8'h00);
        chk(8'h00, 1'b0, 8'hE0, "held_at_reset");
        io(5'b00000, 8'h00);
        io(5'b00100, 8'h00);
        repeat (DLY) io(5'b00100, 8'h00);
        chk(8'h04, 1'b0, 8'hE4, "rearm");
        mm(1'b0, 1'b1, 8'h00, 5'b00000, 8'h00);
        repeat (DLY + 1) io(5'b00000, 8'h00);

        // Single pulse then acknowledge
        io(5'b00001, 8'h00);
        repeat (DLY) io(5'b00000, 8'h00);
        chk(8'h01, 1'b0, 8'hE1, "pulse0");
        io(5'b00000, 8'h01);
        chk(8'h00, 1'b0, 8'hE0, "ack0");

        // Held line sets once; ack clears it and it stays clear
        for (int i = 0; i < 10; i++) io(5'b00100, (i == 3 + DLY) ? 8'h04 : 8'h00);
        chk(8'h00, 1'b0, 8'hE0, "hold_no_reset");
        repeat (DLY + 1) io(5'b00000, 8'h00);

        // MMIO write/read
        mm(1'b0, 1'b1, 8'hFF, 5'b00000, 8'h00);
        chk(8'h1F, 1'b0, 8'hFF, "wr_ff");
        mm(1'b1, 1'b0, 8'h00, 5'b00000, 8'h00);
        chk(8'h1F, 1'b1, 8'hFF, "rd_ff");
        mm(1'b0, 1'b1, 8'h00, 5'b00000, 8'h00);
        chk(8'h00, 1'b0, 8'hE0, "wr_00");
        mm(1'b1, 1'b0, 8'h00, 5'b00000, 8'h00);
        chk(8'h00, 1'b1, 8'hE0, "rd_00");
        mm(1'b1, 1'b1, 8'hF5, 5'b00000, 8'h00);
        chk(8'h15, 1'b1, 8'hF5, "rd_wr");
        io(5'b00000, 8'hFF);
        chk(8'h00, 1'b0, 8'hE0, "ack_all");

        // Edge, write of 0 and ack all on bit 1 at the same edge: edge wins
        for (int j = 0; j < DLY; j++) io(5'b00010, 8'h00);
        mm(1'b0, 1'b1, 8'h00, 5'b00010, 8'h02);
        chk(8'h02, 1'b0, 8'hE2, "coincide");
        io(5'b00000, 8'h02);
        repeat (DLY) io(5'b00000, 8'h00);

        // Set latency on bit 4
        io(5'b10000, 8'h00);
`ifdef IRQ_SYNC_EN
        chk(8'h00, 1'b0, 8'hE0, "lat_k");
        io(5'b10000, 8'h00);
        chk(8'h00, 1'b0, 8'hE0, "lat_k1");
        io(5'b10000, 8'h00);
        chk(8'h10, 1'b0, 8'hF0, "lat_k2");
`else
        chk(8'h10, 1'b0, 8'hF0, "lat_k");
`endif

        // Asynchronous reset mid-cycle, request still held afterwards must not fire
        async_reset();
        repeat (2) cycle(1'b1, 5'b10000, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (DLY + 2) io(5'b10000, 8'h00);
        chk(8'h00, 1'b0, 8'hE0, "post_rst_held");

        // Randomized traffic, scored against the model only
        r_req = 5'b10000;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) < 3) r_req = 5'($urandom_range(0, 31));
            r_ack = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            r_a   = ($urandom_range(0, 1) == 1) ? 16'hFF0F : 16'($urandom_range(16'hFF00, 16'hFFFF));
            cycle(($urandom_range(0, 49) == 0), r_req, r_ack, r_a,
                  ($urandom_range(0, 3) != 0), 8'($urandom),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 6) == 0));
        end

        @(posedge CLK);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
